// File: rtl/mem_pkg.sv
// Shared types and helpers for the sram read/write port arbiter.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } mem_owner_t;

    // Byte address to full word index; callers truncate to the sram depth.
    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one sram read port between imem and dmem, routes responses back,
// and drives the sram write port directly from dmem writes.
module sram_arbiter
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH        = 1024,
    parameter  int unsigned STARVE_LIMIT = 4,
    localparam int unsigned LOGDEPTH     = $clog2(DEPTH),
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                imem_req,
    input  logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_gnt,
    output logic                imem_rvalid,
    output logic [DATA_W-1:0]   imem_rdata,

    input  logic                dmem_req,
    input  logic                dmem_we,
    input  logic [BE_W-1:0]     dmem_be,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic                dmem_gnt,
    output logic                dmem_rvalid,
    output logic [DATA_W-1:0]   dmem_rdata,

    output logic                sram_read_req,
    output logic [LOGDEPTH-1:0] sram_read_addr,
    input  logic [DATA_W-1:0]   sram_read_data,
    output logic                sram_write_req,
    output logic [LOGDEPTH-1:0] sram_write_addr,
    output logic [BE_W-1:0]     sram_write_byte_en,
    output logic [DATA_W-1:0]   sram_write_data
);

    logic [CNT_W-1:0]    r_starve;
    mem_owner_t          r_owner;

    logic [LOGDEPTH-1:0] w_i_idx;
    logic [LOGDEPTH-1:0] w_d_idx;
    logic                w_d_wr;
    logic                w_d_rd;
    logic                w_hazard;
    logic                w_starved;
    logic                w_i_win;
    logic                w_d_win;
    logic [CNT_W-1:0]    w_starve_nxt;
    mem_owner_t          w_owner_nxt;

    assign w_i_idx   = LOGDEPTH'(word_idx(imem_addr));
    assign w_d_idx   = LOGDEPTH'(word_idx(dmem_addr));
    assign w_starved = (r_starve == CNT_W'(STARVE_LIMIT));

    // Read-port priority: dmem first unless imem has lost STARVE_LIMIT times in a row.
    always_comb begin
        w_d_wr   = 1'b0;
        w_d_rd   = 1'b0;
        w_hazard = 1'b0;
        w_i_win  = 1'b0;
        w_d_win  = 1'b0;
        if (reset_n) begin
            w_d_wr   = dmem_req && dmem_we;
            w_d_rd   = dmem_req && !dmem_we;
            // Same-word write and imem read would return stale data; hold imem off one cycle.
            w_hazard = w_d_wr && (w_i_idx == w_d_idx);
            if (imem_req && !w_hazard && (!w_d_rd || w_starved)) begin
                w_i_win = 1'b1;
            end else if (w_d_rd) begin
                w_d_win = 1'b1;
            end
        end
    end

    // Next starve count and read owner.
    always_comb begin
        w_starve_nxt = '0;
        w_owner_nxt  = OWN_NONE;
        if (imem_req && !w_i_win) begin
            w_starve_nxt = w_starved ? r_starve : r_starve + CNT_W'(1);
        end
        if (w_i_win) begin
            w_owner_nxt = OWN_IMEM;
        end else if (w_d_win) begin
            w_owner_nxt = OWN_DMEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_owner  <= OWN_NONE;
        end else begin
            r_starve <= w_starve_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    assign imem_gnt    = w_i_win;
    assign dmem_gnt    = w_d_wr || w_d_win;

    // Reset also squashes a response already in flight.
    assign imem_rvalid = reset_n && (r_owner == OWN_IMEM);
    assign dmem_rvalid = reset_n && (r_owner == OWN_DMEM);
    assign imem_rdata  = sram_read_data;
    assign dmem_rdata  = sram_read_data;

    assign sram_read_req      = w_i_win || w_d_win;
    assign sram_read_addr     = w_i_win ? w_i_idx : w_d_idx;
    assign sram_write_req     = w_d_wr;
    assign sram_write_addr    = w_d_idx;
    assign sram_write_byte_en = dmem_be;
    assign sram_write_data    = dmem_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: sram model, per-cycle reference model check and directed literal checks.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        sram_read_req;
    logic [9:0]  sram_read_addr;
    logic [31:0] sram_read_data;
    logic        sram_write_req;
    logic [9:0]  sram_write_addr;
    logic [3:0]  sram_write_byte_en;
    logic [31:0] sram_write_data;

    int n_cmp = 0;
    int n_bad = 0;

    sram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .sram_read_req(sram_read_req), .sram_read_addr(sram_read_addr),
        .sram_read_data(sram_read_data), .sram_write_req(sram_write_req),
        .sram_write_addr(sram_write_addr), .sram_write_byte_en(sram_write_byte_en),
        .sram_write_data(sram_write_data)
    );

    always #5 clk = ~clk;

    // Attached sram: registered read data, byte-enabled write.
    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    always @(posedge clk) begin
        if (sram_read_req) sram_read_data <= mem[sram_read_addr];
        if (sram_write_req) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who should win this cycle, and what the previous winner gets back.
    int          m_starve = 0;
    int          m_pend   = 0;   // 0 none, 1 imem, 2 dmem
    logic [31:0] m_pdata  = '0;

    always @(negedge clk) begin
        logic        e_ig, e_dg, d_write, d_read, i_ok;
        logic [9:0]  iw, dw, ridx;
        iw = imem_addr[11:2];
        dw = dmem_addr[11:2];

        chkb("m_imem_rvalid", imem_rvalid, reset_n && m_pend == 1);
        chkb("m_dmem_rvalid", dmem_rvalid, reset_n && m_pend == 2);
        if (reset_n && m_pend == 1) chk("m_imem_rdata", imem_rdata, m_pdata);
        if (reset_n && m_pend == 2) chk("m_dmem_rdata", dmem_rdata, m_pdata);

        e_ig = 1'b0; e_dg = 1'b0; ridx = '0;
        d_write = reset_n && dmem_req && dmem_we;
        d_read  = reset_n && dmem_req && !dmem_we;
        i_ok    = reset_n && imem_req && !(d_write && iw == dw);
        if (d_read && i_ok && m_starve >= 4) begin e_ig = 1'b1; ridx = iw; end
        else if (d_read)                     begin e_dg = 1'b1; ridx = dw; end
        else if (i_ok)                       begin e_ig = 1'b1; ridx = iw; end
        if (d_write) e_dg = 1'b1;

        chkb("m_imem_gnt", imem_gnt, e_ig);
        chkb("m_dmem_gnt", dmem_gnt, e_dg);
        chkb("m_sram_read_req", sram_read_req, e_ig || (e_dg && !d_write));
        if (e_ig || (e_dg && !d_write)) chk("m_sram_read_addr", 32'(sram_read_addr), 32'(ridx));
        chkb("m_sram_write_req", sram_write_req, d_write);
        if (d_write) begin
            chk("m_sram_write_addr", 32'(sram_write_addr), 32'(dw));
            chk("m_sram_write_be", 32'(sram_write_byte_en), 32'(dmem_be));
            chk("m_sram_write_data", sram_write_data, dmem_wdata);
        end

        if (!reset_n) begin
            m_pend = 0; m_starve = 0;
        end else begin
            m_pend  = e_ig ? 1 : ((e_dg && !d_write) ? 2 : 0);
            m_pdata = shadow[ridx];
            if (d_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (dmem_be[b]) shadow[dw][8*b +: 8] = dmem_wdata[8*b +: 8];
                end
            end
            if (imem_req && !e_ig) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
            else                   m_starve = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_d(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        dmem_req = req; dmem_we = we; dmem_be = be; dmem_addr = addr; dmem_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h1000_0000 + 32'(i);
            shadow[i] = 32'h1000_0000 + 32'(i);
        end
        mem[5] = 32'hDEADBEEF;    shadow[5] = 32'hDEADBEEF;
        mem[8] = 32'hFFFFFFFF;    shadow[8] = 32'hFFFFFFFF;

        // Reset held with both requests pending.
        reset_n = 1'b0;
        imem_req = 1'b1; imem_addr = 32'h0;
        drv_d(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chkb("rst_imem_gnt", imem_gnt, 1'b0);
            chkb("rst_dmem_gnt", dmem_gnt, 1'b0);
            chkb("rst_read_req", sram_read_req, 1'b0);
            chkb("rst_write_req", sram_write_req, 1'b0);
            chkb("rst_rvalid", imem_rvalid || dmem_rvalid, 1'b0);
        end
        reset_n = 1'b1;
        #1;
        chkb("t1_dmem_first", dmem_gnt, 1'b1);
        chkb("t1_imem_loses", imem_gnt, 1'b0);
        step();
        imem_req = 1'b0; dmem_req = 1'b0;
        #1;
        chkb("t1_dmem_rvalid", dmem_rvalid, 1'b1);
        chk("t1_dmem_rdata", dmem_rdata, 32'hDEADBEEF);

        // Lone imem read of word 5.
        step();
        imem_req = 1'b1; imem_addr = 32'h14;
        #1;
        chkb("t2_imem_gnt", imem_gnt, 1'b1);
        step();
        imem_req = 1'b0;
        #1;
        chkb("t2_imem_rvalid", imem_rvalid, 1'b1);
        chk("t2_imem_rdata", imem_rdata, 32'hDEADBEEF);
        chkb("t2_dmem_rvalid", dmem_rvalid, 1'b0);

        // Partial write concurrent with an imem read of a different word.
        step();
        drv_d(1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234ABCD);
        imem_req = 1'b1; imem_addr = 32'h24;
        #1;
        chkb("t3_dmem_gnt", dmem_gnt, 1'b1);
        chkb("t3_imem_gnt", imem_gnt, 1'b1);
        step();
        imem_req = 1'b0; dmem_req = 1'b0;
        #1;
        chk("t3_imem_rdata", imem_rdata, 32'h10000009);
        step();
        drv_d(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        step();
        dmem_req = 1'b0;
        #1;
        chkb("t3_dmem_rvalid", dmem_rvalid, 1'b1);
        chk("t3_merged", dmem_rdata, 32'hFFFFABCD);

        // Same-word write/read hazard.
        step();
        drv_d(1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        imem_req = 1'b1; imem_addr = 32'h40;
        #1;
        chkb("t4_hazard_imem", imem_gnt, 1'b0);
        chkb("t4_hazard_dmem", dmem_gnt, 1'b1);
        step();
        dmem_req = 1'b0;
        #1;
        chkb("t4_retry_gnt", imem_gnt, 1'b1);
        step();
        imem_req = 1'b0;
        #1;
        chk("t4_new_data", imem_rdata, 32'hCAFEF00D);

        // Starvation: imem wins every fifth cycle against continuous dmem reads.
        step();
        imem_req = 1'b1; imem_addr = 32'h0;
        drv_d(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chkb("t5_imem_gnt", imem_gnt, (c == 4) || (c == 9));
            chkb("t5_dmem_gnt", dmem_gnt, !((c == 4) || (c == 9)));
            step();
        end
        imem_req = 1'b0; dmem_req = 1'b0;

        // Reset the cycle after an imem grant drops the response.
        step();
        imem_req = 1'b1; imem_addr = 32'h14;
        #1;
        chkb("t6_imem_gnt", imem_gnt, 1'b1);
        step();
        imem_req = 1'b0; reset_n = 1'b0;
        #1;
        chkb("t6_dropped", imem_rvalid, 1'b0);
        step();
        reset_n = 1'b1;
        #1;
        chkb("t6_no_late_rvalid", imem_rvalid, 1'b0);
        imem_req = 1'b1;
        #1;
        chkb("t6_regrant", imem_gnt, 1'b1);
        step();
        imem_req = 1'b0;
        #1;
        chkb("t6_rvalid", imem_rvalid, 1'b1);
        chk("t6_rdata", imem_rdata, 32'hDEADBEEF);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
